// File: rtl/baccarat_round_fsm.sv
// Dealer controller for one baccarat round: loads six card registers, applies the
// natural / third-card rules, latches winner flags. Optional: BACCARAT_AUTO_DEAL_EN.
module baccarat_round_fsm (
  input  logic       slow_clock,
  input  logic       reset,
  input  logic       deal,
  input  logic [3:0] new_card,
  input  logic [3:0] pscore,
  input  logic [3:0] dscore,
  output logic [3:0] pcard1,
  output logic [3:0] pcard2,
  output logic [3:0] pcard3,
  output logic [3:0] dcard1,
  output logic [3:0] dcard2,
  output logic [3:0] dcard3,
  output logic       player_win,
  output logic       dealer_win,
  output logic       done
);

  typedef enum logic [3:0] {
    S_P1, S_D1, S_P2, S_D2, S_EVAL1, S_P3, S_EVAL2, S_D3, S_RESULT, S_DONE
  } state_t;

  state_t     r_state;
  logic [3:0] r_pcard1, r_pcard2, r_pcard3;
  logic [3:0] r_dcard1, r_dcard2, r_dcard3;
  logic       r_player_win, r_dealer_win, r_done;

  logic       w_step;
  logic       w_card_ok;
  logic       w_natural;
  logic [3:0] w_p3_face;
  logic       w_banker_draws;

`ifdef BACCARAT_AUTO_DEAL_EN
  assign w_step = 1'b1;
`else
  assign w_step = deal;
`endif

  assign w_card_ok = (new_card != 4'd0) && (new_card <= 4'd13);
  assign w_natural = (pscore >= 4'd8) || (dscore >= 4'd8);
  assign w_p3_face = (r_pcard3 >= 4'd10) ? 4'd0 : r_pcard3;

  // Banker tableau once the player has drawn a third card.
  always_comb begin
    w_banker_draws = 1'b0;
    case (dscore)
      4'd0, 4'd1, 4'd2: w_banker_draws = 1'b1;
      4'd3:             w_banker_draws = (w_p3_face != 4'd8);
      4'd4:             w_banker_draws = (w_p3_face >= 4'd2) && (w_p3_face <= 4'd7);
      4'd5:             w_banker_draws = (w_p3_face >= 4'd4) && (w_p3_face <= 4'd7);
      4'd6:             w_banker_draws = (w_p3_face >= 4'd6) && (w_p3_face <= 4'd7);
      default:          w_banker_draws = 1'b0;
    endcase
  end

  always_ff @(posedge slow_clock or posedge reset) begin
    if (reset) begin
      r_state      <= S_P1;
      r_pcard1     <= 4'd0;
      r_pcard2     <= 4'd0;
      r_pcard3     <= 4'd0;
      r_dcard1     <= 4'd0;
      r_dcard2     <= 4'd0;
      r_dcard3     <= 4'd0;
      r_player_win <= 1'b0;
      r_dealer_win <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      case (r_state)
        S_P1: if (w_step && w_card_ok) begin
          r_pcard1 <= new_card;
          r_state  <= S_D1;
        end
        S_D1: if (w_step && w_card_ok) begin
          r_dcard1 <= new_card;
          r_state  <= S_P2;
        end
        S_P2: if (w_step && w_card_ok) begin
          r_pcard2 <= new_card;
          r_state  <= S_D2;
        end
        S_D2: if (w_step && w_card_ok) begin
          r_dcard2 <= new_card;
          r_state  <= S_EVAL1;
        end
        S_EVAL1: if (w_step) begin
          if (w_natural)              r_state <= S_RESULT;
          else if (pscore <= 4'd5)    r_state <= S_P3;
          else if (dscore <= 4'd5)    r_state <= S_D3;
          else                        r_state <= S_RESULT;
        end
        S_P3: if (w_step && w_card_ok) begin
          r_pcard3 <= new_card;
          r_state  <= S_EVAL2;
        end
        S_EVAL2: if (w_step) begin
          r_state <= w_banker_draws ? S_D3 : S_RESULT;
        end
        S_D3: if (w_step && w_card_ok) begin
          r_dcard3 <= new_card;
          r_state  <= S_RESULT;
        end
        S_RESULT: begin
          r_player_win <= (pscore >= dscore);
          r_dealer_win <= (dscore >= pscore);
          r_done       <= 1'b1;
          r_state      <= S_DONE;
        end
        S_DONE: if (w_step) begin
          // New round: wipe the table, the card on this edge is not loaded.
          r_pcard1     <= 4'd0;
          r_pcard2     <= 4'd0;
          r_pcard3     <= 4'd0;
          r_dcard1     <= 4'd0;
          r_dcard2     <= 4'd0;
          r_dcard3     <= 4'd0;
          r_player_win <= 1'b0;
          r_dealer_win <= 1'b0;
          r_done       <= 1'b0;
          r_state      <= S_P1;
        end
        default: r_state <= S_P1;
      endcase
    end
  end

  assign pcard1     = r_pcard1;
  assign pcard2     = r_pcard2;
  assign pcard3     = r_pcard3;
  assign dcard1     = r_dcard1;
  assign dcard2     = r_dcard2;
  assign dcard3     = r_dcard3;
  assign player_win = r_player_win;
  assign dealer_win = r_dealer_win;
  assign done       = r_done;

endmodule

// File: tb/tb_baccarat_round_fsm.sv
// Directed bench for baccarat_round_fsm; hand scores come from a local scorehand model.
module tb_baccarat_round_fsm;
  logic       slow_clock = 1'b0;
  logic       reset;
  logic       deal;
  logic [3:0] new_card;
  logic [3:0] pscore, dscore;
  logic [3:0] pcard1, pcard2, pcard3, dcard1, dcard2, dcard3;
  logic       player_win, dealer_win, done;

  int checks = 0;
  int errors = 0;

  baccarat_round_fsm dut (
    .slow_clock (slow_clock),
    .reset      (reset),
    .deal       (deal),
    .new_card   (new_card),
    .pscore     (pscore),
    .dscore     (dscore),
    .pcard1     (pcard1),
    .pcard2     (pcard2),
    .pcard3     (pcard3),
    .dcard1     (dcard1),
    .dcard2     (dcard2),
    .dcard3     (dcard3),
    .player_win (player_win),
    .dealer_win (dealer_win),
    .done       (done)
  );

  always #5 slow_clock = ~slow_clock;

  function automatic logic [3:0] face(input logic [3:0] v);
    return (v >= 4'd10) ? 4'd0 : v;
  endfunction

  function automatic logic [3:0] hand(input logic [3:0] a, b, c);
    int s;
    s = int'(face(a)) + int'(face(b)) + int'(face(c));
    return 4'(s % 10);
  endfunction

  // Downstream scorehand instances, modelled combinationally.
  always_comb begin
    pscore = hand(pcard1, pcard2, pcard3);
    dscore = hand(dcard1, dcard2, dcard3);
  end

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step(input logic [3:0] card);
    @(negedge slow_clock);
    deal = 1'b1;
    new_card = card;
    @(posedge slow_clock);
    #1;
    deal = 1'b0;
    $display("deal card=%0d -> p=%0d,%0d,%0d d=%0d,%0d,%0d pw=%0b dw=%0b done=%0b",
             card, pcard1, pcard2, pcard3, dcard1, dcard2, dcard3, player_win, dealer_win, done);
  endtask

  task automatic tick();
    @(posedge slow_clock);
    #1;
  endtask

  task automatic check_result(input string tag, input int pw, input int dw, input int p3, input int d3);
    check({tag, "_done"}, int'(done), 1);
    check({tag, "_pwin"}, int'(player_win), pw);
    check({tag, "_dwin"}, int'(dealer_win), dw);
    check({tag, "_pcard3"}, int'(pcard3), p3);
    check({tag, "_dcard3"}, int'(dcard3), d3);
  endtask

  task automatic new_round(input string tag);
    step(4'd7);
    check({tag, "_clr_pcard1"}, int'(pcard1), 0);
    check({tag, "_clr_dcard2"}, int'(dcard2), 0);
    check({tag, "_clr_flags"}, int'({player_win, dealer_win, done}), 0);
  endtask

  initial begin
    reset = 1'b1;
    deal = 1'b0;
    new_card = 4'd0;
    repeat (2) @(posedge slow_clock);
    #1;
    check("rst_pcard1", int'(pcard1), 0);
    check("rst_flags", int'({player_win, dealer_win, done}), 0);
    @(negedge slow_clock);
    reset = 1'b0;

    // Natural: player 4+5=9 vs banker 2+3=5
    step(4'd4); step(4'd2); step(4'd5); step(4'd3);
    check("nat_loaded_dcard2", int'(dcard2), 3);
    step(4'd1);
    check("nat_eval_not_done", int'(done), 0);
    tick();
    check_result("nat", 1, 0, 0, 0);
    tick();
    check("nat_hold_done", int'(done), 1);
    new_round("nat");

    // Player draws to 1, banker 7 stands
    step(4'd2); step(4'd3); step(4'd3); step(4'd4);
    step(4'd1);
    step(4'd6);
    step(4'd1);
    tick();
    check_result("p3_bstand", 0, 1, 6, 0);
    new_round("p3_bstand");

    // Banker 6 draws on face 6: player 8 vs banker 7
    step(4'd10); step(4'd13); step(4'd2); step(4'd6);
    step(4'd1);
    step(4'd6);
    step(4'd1);
    step(4'd1);
    tick();
    check_result("b6_draw", 1, 0, 6, 1);
    new_round("b6_draw");

    // Banker 3 stands on face 8: player 0 vs banker 3
    step(4'd1); step(4'd1); step(4'd1); step(4'd2);
    step(4'd1);
    step(4'd8);
    step(4'd1);
    tick();
    check_result("b3_face8", 0, 1, 8, 0);
    new_round("b3_face8");

    // Player stands on 7, banker 3 draws directly from EVAL1 to 5
    step(4'd6); step(4'd2); step(4'd1); step(4'd1);
    step(4'd1);
    step(4'd2);
    tick();
    check_result("p_stand_bdraw", 1, 0, 0, 2);
    new_round("p_stand_bdraw");

    // Tie 7-7, both stand
    step(4'd3); step(4'd2); step(4'd4); step(4'd5);
    step(4'd1);
    tick();
    check_result("tie", 1, 1, 0, 0);
    new_round("tie");

    // Invalid cards hold the state
    step(4'd0);
    check("inv0_pcard1", int'(pcard1), 0);
    step(4'd14);
    check("inv14_pcard1", int'(pcard1), 0);
    step(4'd5);
    check("valid_pcard1", int'(pcard1), 5);
    step(4'd15);
    check("inv15_dcard1", int'(dcard1), 0);
    step(4'd9);
    check("valid_dcard1", int'(dcard1), 9);

    // Asynchronous reset mid-cycle
    @(negedge slow_clock);
    #2;
    reset = 1'b1;
    #1;
    check("async_pcard1", int'(pcard1), 0);
    check("async_dcard1", int'(dcard1), 0);
    @(negedge slow_clock);
    reset = 1'b0;
    step(4'd4);
    check("restart_pcard1", int'(pcard1), 4);
    check("restart_dcard1", int'(dcard1), 0);
    step(4'd2); step(4'd5); step(4'd3);
    step(4'd1);
    tick();
    check_result("restart", 1, 0, 0, 0);
    new_round("restart");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/baccarat_round_fsm.md
# baccarat_round_fsm

Sequential dealer controller for one baccarat round. It loads dealt card values into six hand registers and consumes the two combinational hand scores computed from those registers by downstream `scorehand` instances. It applies the natural, player-third-card and banker-third-card rules, then latches the winner flags. It sits between the card source (value 1..13 per deal) and the score/display logic.

## Interface
Parameters: none.

- `slow_clock`  in  1  sole clock; all state changes on rising edge
- `reset`  in  1  asynchronous, active-high; clears all state immediately
- `deal`  in  1  step strobe; one FSM step per rising edge with `deal`=1
- `new_card`  in  4  card to load this step; legal 1..13 (11..13 = J/Q/K)
- `pscore`  in  4  player hand score (0..9) from `scorehand` on `pcard1..3`, same cycle
- `dscore`  in  4  banker hand score (0..9) from `scorehand` on `dcard1..3`, same cycle
- `pcard1`, `pcard2`, `pcard3`  out  4 each  player card registers; 0 = empty
- `dcard1`, `dcard2`, `dcard3`  out  4 each  banker card registers; 0 = empty
- `player_win`  out  1  registered; 1 when player score ≥ banker score at round end
- `dealer_win`  out  1  registered; 1 when banker score ≥ player score at round end
- `done`  out  1  registered; 1 while in S_DONE

## Operation
- States: S_P1, S_D1, S_P2, S_D2, S_EVAL1, S_P3, S_EVAL2, S_D3, S_RESULT, S_DONE.
- The reset state is S_P1. On reset, every output is 0.
- Load states (S_P1, S_D1, S_P2, S_D2, S_P3, S_D3):
  - On a `deal` edge, write `new_card` to the matching register and advance.
  - Order: P1 → D1 → P2 → D2 → EVAL1. P3 → EVAL2. D3 → RESULT.
- Invalid card: if `new_card` is 0, 14 or 15 on a load-state `deal` edge, nothing is written and the state holds.
- S_EVAL1 (on a `deal` edge, no load):
  - `pscore` or `dscore` is 8 or 9 → S_RESULT.
  - Else `pscore` ≤ 5 → S_P3.
  - Else `dscore` ≤ 5 → S_D3.
  - Else → S_RESULT.
- S_EVAL2 (on a `deal` edge, no load):
  - Let f = face value of `pcard3` (10..13 → 0).
  - Banker draws (→ S_D3) when:
    - `dscore` 0..2;
    - `dscore` 3 and f ≠ 8;
    - `dscore` 4 and f in 2..7;
    - `dscore` 5 and f in 4..7;
    - `dscore` 6 and f in 6..7.
  - Otherwise → S_RESULT.
- S_RESULT:
  - Advances to S_DONE on the next clock; `deal` is not required.
  - Latch `player_win` = (`pscore` ≥ `dscore`) and `dealer_win` = (`dscore` ≥ `pscore`). A tie sets both.
- S_DONE:
  - Holds flags, cards and `done`.
  - A `deal` edge clears all six cards, both flags and `done`, and goes to S_P1. No card is loaded on that edge.
- Asserting `reset` in any state aborts the round.

## Timing
- A loaded card is visible on its output register after the `deal` edge. The score inputs reflect it within the same cycle, because `scorehand` is combinational.
- EVAL decisions use the scores from the cycle of the `deal` edge. These always include the last-loaded card, since each EVAL is at least one edge after it.
- Latency:
  - Natural round: 5 `deal` edges plus 1 clock to `done`=1.
  - Full round: 8 `deal` edges plus 1 clock.
- `deal` held high steps once per clock. There is no edge detection.
- Reset is asynchronous. Outputs go to 0 without waiting for a clock edge, and the FSM resumes at S_P1 on the first `deal` edge after release.

## Configuration
- `BACCARAT_AUTO_DEAL_EN`
  - Defined: `deal` is ignored and treated as constantly 1, so the FSM steps every clock. This is for simulation and free-running demo. Invalid-card holds still apply.
  - Undefined: steps occur only on `deal` edges, as described above.

## Test plan
1. Natural: reset, then deal cards 4, 2, 5, 3, then one more `deal` (EVAL1) → S_RESULT → next clock `done`=1, `player_win`=1, `dealer_win`=0, `pcard3`=`dcard3`=0.
2. Player draws, banker stands:
   - Stimulus: P 2,3 (score 5), D 3,4 (score 7), P3=6 (player score 1).
   - EVAL2 takes the no-draw path → `dealer_win`=1, `player_win`=0, `dcard3`=0.
3. Banker 6 draws on face 6:
   - Stimulus: P 10,2 (score 2), D 13,6 (score 6), P3=6 (player score 8), D3=1 (banker score 7).
   - Response: `player_win`=1, `dealer_win`=0.
4. Tie with both standing:
   - Stimulus: P 3,4 (score 7), D 2,5 (score 7).
   - EVAL1 → S_RESULT; both flags 1.
5. Invalid card: in S_P1 with `deal`=1, `new_card`=0 then 14 → `pcard1` stays 0 and the state holds. Then `new_card`=5 → `pcard1`=5.
6. Reset and restart:
   - Assert `reset` mid-cycle after D1 loaded → all outputs 0 immediately. Re-deal completes normally.
   - From S_DONE, a `deal` edge clears all cards and flags.
